// File: rtl/osg_seq_pkg.sv
// Shared encodings, counter width and default timing for the run sequencer.
package osg_seq_pkg;

  localparam int CNT_W           = 28;
  localparam int DEF_NCH         = 16;
  localparam int DEF_STAGGER_CYC = 16;
  localparam int DEF_HOLD_CYC    = 100000000;
  localparam int DEF_TIMEOUT_CYC = 200000000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HOLD   = 3'd3
  } seq_state_t;

  typedef logic [CNT_W-1:0] cnt_t;

  // Saturating increment so a stuck run can never wrap the timeout counter.
  function automatic cnt_t sat_inc(input cnt_t c);
    return (&c) ? c : c + cnt_t'(1);
  endfunction

endpackage

// File: rtl/osg_run_sequencer_if.sv
// Bundle of the sequencer's trigger, channel and status signals.
interface osg_run_sequencer_if
  import osg_seq_pkg::*;
#(
  parameter int NCH = DEF_NCH
) (
  input logic sq_clk
);

  // Triggers are asynchronous pins (button active-low, others active-high);
  // ch_mask is sampled only when a trigger is accepted, end_flg is a level,
  // done/timeout are single-cycle pulses, state is the live FSM encoding.
  logic           button_n;
  logic           pc_start;
  logic           ellight;
  logic [NCH-1:0] ch_mask;
  logic [NCH-1:0] end_flg;
  logic [NCH-1:0] ch_go;
  logic           busy;
  logic           done;
  logic           timeout;
  logic [2:0]     state;

  modport master (
    input  sq_clk, ch_go, busy, done, timeout, state,
    output button_n, pc_start, ellight, ch_mask, end_flg
  );

  modport slave (
    input  sq_clk, button_n, pc_start, ellight, ch_mask, end_flg,
    output ch_go, busy, done, timeout, state
  );

endinterface

// File: rtl/osg_trig_sync.sv
// Two-flop synchronizer plus rising-edge detector for one asynchronous trigger pin.
module osg_trig_sync #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic sq_clk,
  input  logic sq_rst,
  input  logic din,
  output logic rise
);

  logic lvl;
  logic s1, s2, s3;

  // Active-low pins are inverted up front so a falling pin edge is a rising level edge.
  assign lvl = ACTIVE_LOW ? ~din : din;

  always_ff @(posedge sq_clk or posedge sq_rst) begin
    if (sq_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= lvl;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/osg_run_sequencer.sv
// Run sequencer: staggered per-channel launch, wait for all end flags, hold, then release.
module osg_run_sequencer
  import osg_seq_pkg::*;
#(
  parameter int NCH         = DEF_NCH,
  parameter int STAGGER_CYC = DEF_STAGGER_CYC,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic           sq_clk,
  input  logic           sq_rst,
  input  logic           sq_button_n,
  input  logic           sq_pc_start,
  input  logic           sq_ellight,
  input  logic [NCH-1:0] sq_ch_mask,
  input  logic [NCH-1:0] sq_end_flg,
  output logic [NCH-1:0] sq_ch_go,
  output logic           sq_busy,
  output logic           sq_done,
  output logic           sq_timeout,
  output logic [2:0]     sq_state
);

  localparam cnt_t STAG_LAST = cnt_t'(STAGGER_CYC - 1);
  localparam cnt_t HOLD_LAST = cnt_t'(HOLD_CYC - 1);
  localparam cnt_t TMO_LAST  = cnt_t'(TIMEOUT_CYC - 1);

  seq_state_t     state;
  logic [NCH-1:0] mask_q;
  logic [NCH-1:0] end_lat;
  logic [NCH-1:0] ch_go_q;
  cnt_t           stag_cnt;
  cnt_t           tmo_cnt;
  cnt_t           hold_cnt;
  logic           done_q;
  logic           tmo_q;

  logic rise_btn, rise_pc, rise_el, trig;

  osg_trig_sync #(.ACTIVE_LOW(1'b1)) u_sync_btn (
    .sq_clk(sq_clk), .sq_rst(sq_rst), .din(sq_button_n), .rise(rise_btn)
  );
  osg_trig_sync #(.ACTIVE_LOW(1'b0)) u_sync_pc (
    .sq_clk(sq_clk), .sq_rst(sq_rst), .din(sq_pc_start), .rise(rise_pc)
  );
  osg_trig_sync #(.ACTIVE_LOW(1'b0)) u_sync_el (
    .sq_clk(sq_clk), .sq_rst(sq_rst), .din(sq_ellight), .rise(rise_el)
  );

  assign trig = rise_btn | rise_pc | rise_el;

  logic [NCH-1:0] pending;
  logic [NCH-1:0] next_ch;
  logic [NCH-1:0] first_ch;
  logic           all_done;

  // x & -x isolates the lowest set bit, giving ascending-index launch order.
  assign pending  = mask_q & ~ch_go_q;
  assign next_ch  = pending & (~pending + NCH'(1));
  assign first_ch = sq_ch_mask & (~sq_ch_mask + NCH'(1));
  assign all_done = ((end_lat & mask_q) == mask_q);

  always_ff @(posedge sq_clk or posedge sq_rst) begin
    if (sq_rst) begin
      state    <= ST_IDLE;
      mask_q   <= '0;
      end_lat  <= '0;
      ch_go_q  <= '0;
      stag_cnt <= '0;
      tmo_cnt  <= '0;
      hold_cnt <= '0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      end_lat <= end_lat | (sq_end_flg & ch_go_q);
      case (state)
        ST_IDLE: begin
          // The done/timeout pulse cycle is still part of the finished run.
          if (trig && (|sq_ch_mask) && !done_q && !tmo_q) begin
            mask_q   <= sq_ch_mask;
            end_lat  <= '0;
            stag_cnt <= '0;
            tmo_cnt  <= '0;
            hold_cnt <= '0;
            ch_go_q  <= first_ch;
            state    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH, ST_WAIT: begin
          tmo_cnt <= sat_inc(tmo_cnt);
          if (all_done) begin
            hold_cnt <= '0;
            state    <= ST_HOLD;
          end else if (tmo_cnt >= TMO_LAST) begin
            ch_go_q <= '0;
            tmo_q   <= 1'b1;
            state   <= ST_IDLE;
          end else if (state == ST_LAUNCH) begin
            if (pending == '0) begin
              state <= ST_WAIT;
            end else if (stag_cnt >= STAG_LAST) begin
              ch_go_q  <= ch_go_q | next_ch;
              stag_cnt <= '0;
            end else begin
              stag_cnt <= stag_cnt + cnt_t'(1);
            end
          end
        end
        ST_HOLD: begin
          if (hold_cnt >= HOLD_LAST) begin
            ch_go_q <= '0;
            done_q  <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + cnt_t'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sq_ch_go   = ch_go_q;
  assign sq_busy    = (state != ST_IDLE);
  assign sq_done    = done_q;
  assign sq_timeout = tmo_q;
  assign sq_state   = state;

endmodule

// File: tb/tb_osg_run_sequencer.sv
// Directed bench for osg_run_sequencer with NCH=4, STAGGER=2, HOLD=10, TIMEOUT=50.
module tb_osg_run_sequencer;

  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  osg_run_sequencer_if #(.NCH(NCH)) bus (.sq_clk(clk));

  osg_run_sequencer #(
    .NCH(NCH), .STAGGER_CYC(2), .HOLD_CYC(10), .TIMEOUT_CYC(50)
  ) dut (
    .sq_clk(clk),
    .sq_rst(rst),
    .sq_button_n(bus.button_n),
    .sq_pc_start(bus.pc_start),
    .sq_ellight(bus.ellight),
    .sq_ch_mask(bus.ch_mask),
    .sq_end_flg(bus.end_flg),
    .sq_ch_go(bus.ch_go),
    .sq_busy(bus.busy),
    .sq_done(bus.done),
    .sq_timeout(bus.timeout),
    .sq_state(bus.state)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulses pc_start for one cycle; returns sampling in the first LAUNCH cycle.
  task automatic start_pc(input logic [NCH-1:0] mask);
    bus.ch_mask  = mask;
    bus.pc_start = 1'b1;
    tick();
    bus.pc_start = 1'b0;
    tick(2);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_wait: done=%b after %0d cycles, required 1", name, bus.done, n);
    end
  endtask

  task automatic test_reset();
    bus.button_n = 1'b1;
    bus.pc_start = 1'b0;
    bus.ellight  = 1'b0;
    bus.ch_mask  = '0;
    bus.end_flg  = '0;
    rst = 1'b1;
    tick(3);
    checks++;
    if ({bus.state, bus.ch_go, bus.busy, bus.done, bus.timeout} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: state=%0d go=%b busy=%b done=%b tmo=%b, required all 0",
               bus.state, bus.ch_go, bus.busy, bus.done, bus.timeout);
    end
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_stagger();
    logic [2:0]     exp_st [19];
    logic [NCH-1:0] exp_go [19];
    exp_st = '{1, 1, 1, 1, 1, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 0, 0};
    exp_go = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b1011, 4'b1011, 4'b1011,
               4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011,
               4'b1011, 4'b1011, 4'b1011, 4'b0000, 4'b0000};
    bus.ch_mask  = 4'b1011;
    bus.pc_start = 1'b1;
    tick();
    bus.pc_start = 1'b0;
    tick();
    checks++;
    if (bus.state !== 3'd0) begin
      errors++;
      $display("FAIL stagger_sync_latency: state=%0d, required 0", bus.state);
    end
    tick();
    for (int i = 0; i < 19; i++) begin
      checks++;
      if (bus.state !== exp_st[i] || bus.ch_go !== exp_go[i] || bus.busy !== (exp_st[i] != 0)) begin
        errors++;
        $display("FAIL stagger_L%0d: state=%0d go=%b busy=%b, required state=%0d go=%b",
                 i, bus.state, bus.ch_go, bus.busy, exp_st[i], exp_go[i]);
      end
      checks++;
      if (bus.done !== (i == 17) || bus.timeout !== 1'b0) begin
        errors++;
        $display("FAIL stagger_pulse_L%0d: done=%b tmo=%b, required done=%b tmo=0",
                 i, bus.done, bus.timeout, (i == 17));
      end
      if (i == 5) bus.end_flg = 4'b1111;
      tick();
    end
    bus.end_flg = '0;
  endtask

  task automatic test_timeout();
    bus.end_flg = '0;
    start_pc(4'b0001);
    checks++;
    if (bus.state !== 3'd1 || bus.ch_go !== 4'b0001) begin
      errors++;
      $display("FAIL timeout_launch: state=%0d go=%b, required 1/0001", bus.state, bus.ch_go);
    end
    tick(49);
    checks++;
    if (bus.state !== 3'd2 || bus.timeout !== 1'b0 || bus.ch_go !== 4'b0001) begin
      errors++;
      $display("FAIL timeout_L49: state=%0d tmo=%b go=%b, required 2/0/0001",
               bus.state, bus.timeout, bus.ch_go);
    end
    tick();
    checks++;
    if (bus.state !== 3'd0 || bus.timeout !== 1'b1 || bus.done !== 1'b0 || bus.ch_go !== 4'b0000) begin
      errors++;
      $display("FAIL timeout_L50: state=%0d tmo=%b done=%b go=%b, required 0/1/0/0000",
               bus.state, bus.timeout, bus.done, bus.ch_go);
    end
    tick();
    checks++;
    if (bus.timeout !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_L51: tmo=%b done=%b, required 0/0", bus.timeout, bus.done);
    end
  endtask

  task automatic test_zero_mask();
    bus.ch_mask  = '0;
    bus.button_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (bus.state !== 3'd0 || bus.ch_go !== 4'b0000) begin
        errors++;
        $display("FAIL zero_mask_c%0d: state=%0d go=%b, required 0/0000", i, bus.state, bus.ch_go);
      end
    end
    bus.button_n = 1'b1;
    tick(4);
  endtask

  task automatic test_hold_ignore();
    int ndone;
    ndone = 0;
    bus.end_flg = 4'b0001;
    start_pc(4'b0001);
    for (int i = 0; i <= 20; i++) begin
      if (bus.done === 1'b1) ndone++;
      if (i == 2 || i == 11) begin
        checks++;
        if (bus.state !== 3'd3) begin
          errors++;
          $display("FAIL hold_L%0d: state=%0d, required 3", i, bus.state);
        end
      end
      if (i >= 12) begin
        checks++;
        if (bus.state !== 3'd0 || bus.done !== (i == 12)) begin
          errors++;
          $display("FAIL hold_after_L%0d: state=%0d done=%b, required 0/%b",
                   i, bus.state, bus.done, (i == 12));
        end
      end
      if (i == 3)  bus.ellight  = 1'b1;
      if (i == 4)  bus.ellight  = 1'b0;
      if (i == 10) bus.pc_start = 1'b1;
      if (i == 11) bus.pc_start = 1'b0;
      tick();
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL hold_done_count: saw %0d done pulses, required 1", ndone);
    end
    bus.end_flg = '0;
  endtask

  task automatic test_reset_mid();
    bus.end_flg = '0;
    start_pc(4'b1111);
    tick(7);
    checks++;
    if (bus.state !== 3'd2 || bus.ch_go !== 4'b1111) begin
      errors++;
      $display("FAIL rstmid_wait: state=%0d go=%b, required 2/1111", bus.state, bus.ch_go);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.state, bus.ch_go, bus.busy, bus.done, bus.timeout} !== 10'b0) begin
      errors++;
      $display("FAIL rstmid_async: state=%0d go=%b busy=%b done=%b tmo=%b, required all 0",
               bus.state, bus.ch_go, bus.busy, bus.done, bus.timeout);
    end
    tick(2);
    rst = 1'b0;
    tick();
    bus.end_flg = 4'b0001;
    start_pc(4'b0001);
    checks++;
    if (bus.state !== 3'd1 || bus.ch_go !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_restart: state=%0d go=%b, required 1/0001", bus.state, bus.ch_go);
    end
    wait_done("rstmid", 40);
    bus.end_flg = '0;
    tick(2);
  endtask

  task automatic test_early_end();
    bus.end_flg = 4'b1000;
    start_pc(4'b1001);
    checks++;
    if (bus.ch_go !== 4'b0001) begin
      errors++;
      $display("FAIL early_L0: go=%b, required 0001", bus.ch_go);
    end
    tick();
    bus.end_flg = 4'b1001;
    tick();
    checks++;
    if (bus.state !== 3'd1 || bus.ch_go !== 4'b1001) begin
      errors++;
      $display("FAIL early_L2: state=%0d go=%b, required 1/1001", bus.state, bus.ch_go);
    end
    tick();
    checks++;
    if (bus.state !== 3'd2) begin
      errors++;
      $display("FAIL early_L3: state=%0d, required 2", bus.state);
    end
    tick();
    checks++;
    if (bus.state !== 3'd3) begin
      errors++;
      $display("FAIL early_L4: state=%0d, required 3", bus.state);
    end
    wait_done("early", 20);
    bus.end_flg = '0;
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stagger();
    tick(3);
    test_timeout();
    tick(3);
    test_zero_mask();
    test_hold_ignore();
    tick(3);
    test_reset_mid();
    test_early_end();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/osg_run_sequencer.md
OSG_RUN_SEQUENCER -- requirements
Module: osg_run_sequencer

Interface
REQ-001 The block SHALL have parameter NCH, default 16, meaning number of channels.
REQ-002 The block SHALL have parameter STAGGER_CYC, default 16, meaning cycles between successive channel launches.
REQ-003 The block SHALL have parameter HOLD_CYC, default 100000000, meaning post-completion hold cycles.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 200000000, meaning max cycles from first launch to all-done.
REQ-005 The block SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-006 The block SHALL have port sq_clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port sq_rst, input, 1 bit: asynchronous active-high reset.
REQ-008 The block SHALL have port sq_button_n, input, 1 bit: front-panel start, active-low, asynchronous.
REQ-009 The block SHALL have port sq_pc_start, input, 1 bit: host start, active-high, asynchronous.
REQ-010 The block SHALL have port sq_ellight, input, 1 bit: optical start, active-high, asynchronous.
REQ-011 The block SHALL have port sq_ch_mask, input, NCH bits: channel enable mask, sampled on accepted trigger.
REQ-012 The block SHALL have port sq_end_flg, input, NCH bits: per-channel end flags, level.
REQ-013 The block SHALL have port sq_ch_go, output, NCH bits: per-channel run enable.
REQ-014 The block SHALL have port sq_busy, output, 1 bit: high in any state except IDLE.
REQ-015 The block SHALL have port sq_done, output, 1 bit: one-cycle pulse on normal completion.
REQ-016 The block SHALL have port sq_timeout, output, 1 bit: one-cycle pulse on timeout abort.
REQ-017 The block SHALL have port sq_state, output, 3 bits: current state encoding.

Function
REQ-018 Each trigger input SHALL pass a 2-flop synchronizer then a rising-edge detector (for sq_button_n, on the falling edge of the raw pin); trigger = OR of the three edges.
REQ-019 States SHALL be IDLE=0, LAUNCH=1, WAIT=2, HOLD=3; sq_state SHALL show the current state.
REQ-020 In IDLE, a trigger with a nonzero sq_ch_mask SHALL latch the mask, clear the end latches, clear both counters, and enter LAUNCH next cycle; a trigger with zero mask SHALL be ignored.
REQ-021 Triggers outside IDLE SHALL be ignored, including on the sq_done/sq_timeout cycle.
REQ-022 LAUNCH SHALL raise sq_ch_go for enabled channels in ascending index, one channel per STAGGER_CYC cycles; the first is raised on the first LAUNCH cycle; disabled channels consume no slot.
REQ-023 After the last enabled channel is raised, the block SHALL enter WAIT next cycle.
REQ-024 A sticky end latch per channel SHALL set when sq_end_flg[i]=1 while sq_ch_go[i]=1; flags of unlaunched or masked channels SHALL be ignored.
REQ-025 When all enabled channels are latched (LAUNCH or WAIT), the block SHALL enter HOLD; sq_ch_go SHALL stay high.
REQ-026 HOLD SHALL last exactly HOLD_CYC cycles; on exit sq_ch_go SHALL clear to 0, sq_done SHALL pulse for 1 cycle, and the block SHALL return to IDLE.
REQ-027 The timeout counter (28 bits, saturating) SHALL run from LAUNCH entry; when it reaches TIMEOUT_CYC in LAUNCH or WAIT, sq_ch_go SHALL clear, sq_timeout SHALL pulse for 1 cycle, and the block SHALL go to IDLE; the timeout counter SHALL NOT run in HOLD.
REQ-028 When all-done and timeout occur in the same cycle, all-done SHALL win.
REQ-029 sq_done and sq_timeout SHALL never be high together.

Reset
REQ-030 sq_rst SHALL immediately force IDLE, sq_ch_go=0, sq_busy=0, sq_done=0, sq_timeout=0, sq_state=0, and clear counters, latches, and synchronizers, including mid-run.
REQ-031 The first trigger edge SHALL be recognized only after the synchronizers refill post-reset (2 cycles minimum).

Structure
REQ-032 Package osg_seq_pkg SHALL hold the state encodings, the 28-bit counter width, and the default NCH/STAGGER/HOLD/TIMEOUT values.
REQ-033 Sub-module osg_trig_sync SHALL implement the synchronizer plus edge detector and SHALL be instantiated three times.

Verification (NCH=4, STAGGER_CYC=2, HOLD_CYC=10, TIMEOUT_CYC=50)
REQ-034 mask=4'b1011, pulse sq_pc_start -> go bits 0,1,3 rise 2 cycles apart; all ends =1 -> HOLD 10 cycles, go=0, sq_done pulse.
REQ-035 mask=4'b0001, end flag never set -> sq_timeout pulse 50 cycles after LAUNCH entry, go=0, sq_done stays 0.
REQ-036 mask=0, sq_button_n low -> state stays IDLE, go=0.
REQ-037 sq_ellight pulse during HOLD -> ignored; the run completes normally with exactly one sq_done.
REQ-038 sq_rst asserted in WAIT with go=4'b1111 -> go=0 and state=IDLE asynchronously; a later trigger starts a clean run.
REQ-039 end flag for channel 3 held high before its launch, mask=4'b1000 plus channel 0 -> channel 3 is latched only once its go bit rises.
